// File: rtl/processor_core_p_if.sv
// Bus between the processor core and its board: instruction ROM port,
// resume control and the debug/observation outputs.
interface processor_core_p_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 7
);
    logic [15:0]       Instr;
    logic              Resume;
    logic [PC_W-1:0]   PC_Out;
    logic [15:0]       IR_Out;
    logic [3:0]        State;
    logic [DATA_W-1:0] ALU_A;
    logic [DATA_W-1:0] ALU_B;
    logic [DATA_W-1:0] ALU_Out;
    logic              Halted;
    logic              Err;

    modport master (
        input  Instr, Resume,
        output PC_Out, IR_Out, State, ALU_A, ALU_B, ALU_Out, Halted, Err
    );

    modport slave (
        output Instr, Resume,
        input  PC_Out, IR_Out, State, ALU_A, ALU_B, ALU_Out, Halted, Err
    );
endinterface

// File: rtl/processor_core_p.sv
// Multi-cycle processor core: FSM controller, 16-entry register file,
// internal data memory and ALU. Instructions come from an external
// combinational ROM addressed by PC_Out.
module processor_core_p #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 7,
    parameter int DMEM_AW = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    processor_core_p_if.master  bus
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ALU    = 4'd7;
    localparam logic [3:0] S_LDI    = 4'd8;
    localparam logic [3:0] S_JZ     = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [PC_W-1:0]    r_pc;
    logic [15:0]        r_ir;
    logic               r_err;
    logic [DATA_W-1:0]  r_rf   [16];
    logic [DATA_W-1:0]  r_dmem [2**DMEM_AW];
    logic [DATA_W-1:0]  r_mdr;

    logic [3:0]         w_op, w_rd, w_ra, w_rb;
    logic [7:0]         w_imm;
    logic [DMEM_AW-1:0] w_daddr;
    logic [DATA_W-1:0]  w_a, w_b, w_alu;
    logic               w_illegal;

    assign w_op      = r_ir[15:12];
    assign w_rd      = r_ir[11:8];
    assign w_ra      = r_ir[7:4];
    assign w_rb      = r_ir[3:0];
    assign w_imm     = r_ir[7:0];
    assign w_daddr   = r_ir[DMEM_AW-1:0];
    assign w_a       = r_rf[w_ra];
    assign w_b       = r_rf[w_rb];
    assign w_illegal = (w_op >= 4'hA) && (w_op <= 4'hE);

    // ALU: logic/arithmetic ops 3-7, everything else passes operand A through
    always_comb begin
        w_alu = w_a;
        case (w_op)
            4'h3:    w_alu = w_a + w_b;
            4'h4:    w_alu = w_a - w_b;
            4'h5:    w_alu = w_a & w_b;
            4'h6:    w_alu = w_a | w_b;
            4'h7:    w_alu = w_a ^ w_b;
            default: w_alu = w_a;
        endcase
    end

    // Next-state: decode dispatch, HALT waits for Resume, execute states return to FETCH
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    4'h0:    w_next = S_NOOP;
                    4'h1:    w_next = S_LOAD_A;
                    4'h2:    w_next = S_STORE;
                    4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                             w_next = S_ALU;
                    4'h8:    w_next = S_LDI;
                    4'h9:    w_next = S_JZ;
                    4'hF:    w_next = S_HALT;
                    default: w_next = S_NOOP;   // illegal ops behave as NOOP
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_HALT:   w_next = bus.Resume ? S_FETCH : S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Architectural state: PC, IR, error flag and register-file writebacks
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    r_ir <= bus.Instr;
                    r_pc <= r_pc + PC_W'(1);
                end
                S_DECODE: if (w_illegal) r_err <= 1'b1;
                S_LOAD_B: r_rf[w_rd] <= r_mdr;
                S_ALU:    r_rf[w_rd] <= w_alu;
                S_LDI:    r_rf[w_rd] <= DATA_W'(w_imm);
                S_JZ:     if (r_rf[w_rd] == '0) r_pc <= w_imm[PC_W-1:0];
                default: ;
            endcase
        end
    end

    // Data memory (never cleared). Reset forces INIT asynchronously, so an
    // aborted STORE can never reach this write.
    always_ff @(posedge Clk) begin
        if (r_state == S_STORE)  r_dmem[w_daddr] <= r_rf[w_rd];
        if (r_state == S_LOAD_A) r_mdr <= r_dmem[w_daddr];
    end

    assign bus.PC_Out  = r_pc;
    assign bus.IR_Out  = r_ir;
    assign bus.State   = r_state;
    assign bus.ALU_A   = w_a;
    assign bus.ALU_B   = w_b;
    assign bus.ALU_Out = w_alu;
    assign bus.Halted  = (r_state == S_HALT);
    assign bus.Err     = r_err;
endmodule

// File: tb/tb_processor_core_p.sv
// Bench for processor_core_p: an instruction-level model expands every
// instruction into its expected per-cycle observations, and a compare step
// checks the DUT against them each cycle. Directed programs pin the model
// with hand-computed values; random programs exercise the rest.
module tb_processor_core_p;
    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic        err;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic [15:0] rom  [128];
    logic [15:0] rom8 [128];

    processor_core_p_if #(.DATA_W(16), .PC_W(7)) io ();
    processor_core_p_if #(.DATA_W(8),  .PC_W(7)) io8 ();
    assign io.Instr   = rom[io.PC_Out];
    assign io8.Instr  = rom8[io8.PC_Out];
    assign io8.Resume = 1'b0;

    processor_core_p #(.DATA_W(16), .PC_W(7), .DMEM_AW(8)) dut (
        .Clk(Clk), .Reset(Reset), .bus(io.master));
    processor_core_p #(.DATA_W(8), .PC_W(7), .DMEM_AW(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .bus(io8.master));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // model state
    logic [6:0]  m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_rf   [16];
    logic [15:0] m_dmem [256];
    logic        m_err, m_halt;
    logic        m_on = 1'b0;
    exp_t        q [$];

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h3:    return a + b;
            4'h4:    return a - b;
            4'h5:    return a & b;
            4'h6:    return a | b;
            4'h7:    return a ^ b;
            default: return a;
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input logic [6:0] pc, input logic [15:0] ir, input logic err);
        exp_t e;
        e.st  = st;
        e.pc  = pc;
        e.ir  = ir;
        e.a   = m_rf[ir[7:4]];
        e.b   = m_rf[ir[3:0]];
        e.o   = alu(ir[15:12], e.a, e.b);
        e.err = err;
        q.push_back(e);
    endtask

    task automatic m_reset();
        m_pc = '0; m_ir = '0; m_err = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        q.delete();
        push(4'd0, 7'd0, 16'h0, 1'b0);
        m_on = 1'b1;
    endtask

    // Execute one instruction: queue its cycles, then apply its effects.
    task automatic gen();
        logic [15:0] ins;
        logic [3:0]  op, rd;
        logic [7:0]  ad;
        logic [6:0]  npc;
        logic        e0;
        ins = rom[m_pc]; op = ins[15:12]; rd = ins[11:8]; ad = ins[7:0];
        npc = m_pc + 7'd1; e0 = m_err;
        push(4'd1, m_pc, m_ir, e0);
        push(4'd2, npc, ins, e0);
        m_ir = ins;
        if (op >= 4'hA && op <= 4'hE) m_err = 1'b1;
        case (op)
            4'h1: begin push(4'd4, npc, ins, m_err); push(4'd5, npc, ins, m_err); end
            4'h2: push(4'd6, npc, ins, m_err);
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7: push(4'd7, npc, ins, m_err);
            4'h8: push(4'd8, npc, ins, m_err);
            4'h9: push(4'd9, npc, ins, m_err);
            4'hF: m_halt = 1'b1;
            default: push(4'd3, npc, ins, m_err);
        endcase
        case (op)
            4'h1: m_rf[rd] = m_dmem[ad];
            4'h2: m_dmem[ad] = m_rf[rd];
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7: m_rf[rd] = alu(op, m_rf[ins[7:4]], m_rf[ins[3:0]]);
            4'h8: m_rf[rd] = {8'h00, ad};
            4'h9: if (m_rf[rd] == 16'h0) npc = ad[6:0];
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic cmp_cycle();
        exp_t e, a;
        e = q[0];
        a = {io.State, io.PC_Out, io.IR_Out, io.ALU_A, io.ALU_B, io.ALU_Out, io.Err};
        total++;
        if (a !== e || io.Halted !== (e.st == 4'd10)) begin
            bad++;
            $display("FAIL cycle t=%0t: got st=%0d pc=%h ir=%h a=%h b=%h o=%h err=%b hlt=%b want st=%0d pc=%h ir=%h a=%h b=%h o=%h err=%b",
                     $time, a.st, a.pc, a.ir, a.a, a.b, a.o, a.err, io.Halted,
                     e.st, e.pc, e.ir, e.a, e.b, e.o, e.err);
        end
    endtask

    // One clock: compare at negedge, drive inputs, advance model at posedge.
    task automatic step(input logic rst_v, input logic res_v);
        exp_t e;
        @(negedge Clk);
        if (m_on) begin
            if (q.size() == 0) begin
                if (m_halt) push(4'd10, m_pc, m_ir, m_err);
                else gen();
            end
            cmp_cycle();
        end
        Reset = rst_v;
        io.Resume = res_v;
        @(posedge Clk);
        if (rst_v) m_reset();
        else if (m_on) begin
            e = q.pop_front();
            if (e.st == 4'd10 && res_v) m_halt = 1'b0;
        end
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input logic res_v, output int n);
        n = 0;
        do begin
            step(1'b0, res_v);
            n++;
        end while (io.State != s && n < 300);
        if (io.State != s) begin
            total++; bad++;
            $display("FAIL wait_state %0d: timed out, state %0d", s, io.State);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0;
        logic [19:0] seq;
        Reset = 1'b1;
        io.Resume = 1'b0;
        for (int i = 0; i < 256; i++) m_dmem[i] = 'x;
        for (int i = 0; i < 128; i++) rom8[i] = 16'h0000;
        rom8[0] = 16'h81FF; rom8[1] = 16'h8201; rom8[2] = 16'h3312;
        rom8[3] = 16'h4421; rom8[4] = 16'h7511; rom8[5] = 16'hF034;

        // Reset aborting an ALU op, then restart from ROM[0]
        clear_rom();
        rom[0] = 16'h8105; rom[1] = 16'h3311; rom[2] = 16'hF030;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        wait_state(4'd7, 1'b0, n);
        step(1'b1, 1'b0);
        chk("rst_state", io.State, 0);
        chk("rst_pc", io.PC_Out, 0);
        chk("rst_ir", io.IR_Out, 0);
        chk("rst_flags", {io.Halted, io.Err}, 0);
        step(1'b0, 1'b0);
        chk("first_fetch_state", io.State, 1);
        chk("first_fetch_pc", io.PC_Out, 0);
        step(1'b0, 1'b0);
        chk("first_fetch_ir", io.IR_Out, 16'h8105);
        wait_state(4'd10, 1'b0, n);
        chk("r3_after_rerun", io.ALU_A, 16'h000A);

        // Arithmetic on both widths
        clear_rom();
        rom[0] = 16'h81FF; rom[1] = 16'h8201; rom[2] = 16'h3312;
        rom[3] = 16'h4421; rom[4] = 16'h7511; rom[5] = 16'hF034; rom[6] = 16'hF050;
        step(1'b1, 1'b0);
        wait_state(4'd10, 1'b0, n);
        chk("arith_cycles", n, 18);
        chk("arith_r3", io.ALU_A, 16'h0100);
        chk("arith_r4", io.ALU_B, 16'hFF02);
        chk("model_r3", m_rf[3], 16'h0100);
        chk("halt_pc", io.PC_Out, 6);
        chk("w8_halted", io8.Halted, 1);
        chk("w8_r3", io8.ALU_A, 8'h00);
        chk("w8_r4", io8.ALU_B, 8'h02);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("halt_hold", {io.Halted, io.State, io.PC_Out}, {1'b1, 4'd10, 7'd6});
        step(1'b0, 1'b1);
        chk("resume_fetch", io.State, 1);
        step(1'b0, 1'b0);
        chk("resume_ir", io.IR_Out, 16'hF050);
        wait_state(4'd10, 1'b0, n);
        chk("xor_r5", io.ALU_A, 16'h0000);

        // Store then load the same address
        clear_rom();
        rom[0] = 16'h815A; rom[1] = 16'h2120; rom[2] = 16'h1620; rom[3] = 16'hF060;
        step(1'b1, 1'b0);
        wait_state(4'd6, 1'b0, n);
        seq = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            seq = {seq[15:0], io.State};
        end
        chk("load_states", seq, 20'h12451);
        wait_state(4'd10, 1'b0, n);
        chk("load_r6", io.ALU_A, 16'h005A);

        // Branches and PC wrap
        clear_rom();
        rom[0] = 16'h8000; rom[1] = 16'h9010; rom[16] = 16'h8701;
        rom[17] = 16'h9710; rom[18] = 16'h907F; rom[127] = 16'h0000;
        step(1'b1, 1'b0);
        wait_state(4'd9, 1'b0, n);
        step(1'b0, 1'b0);
        chk("jz_taken_pc", io.PC_Out, 7'h10);
        wait_state(4'd9, 1'b0, n);
        step(1'b0, 1'b0);
        chk("jz_not_taken_pc", io.PC_Out, 7'h12);
        wait_state(4'd9, 1'b0, n);
        step(1'b0, 1'b0);
        chk("jz_to_7f", io.PC_Out, 7'h7F);
        step(1'b0, 1'b0);
        chk("pc_wrap", io.PC_Out, 7'h00);

        // HALT at ROM[5], Resume held high through an ALU op is ignored
        clear_rom();
        rom[0] = 16'h8102; rom[1] = 16'h3311; rom[5] = 16'hF000;
        rom[6] = 16'h8933; rom[7] = 16'hF090;
        step(1'b1, 1'b0);
        wait_state(4'd7, 1'b1, n0);
        step(1'b0, 1'b1);
        chk("resume_in_alu", io.State, 1);
        wait_state(4'd10, 1'b0, n);
        chk("halt_entry_cycles", n0 + 1 + n, 18);
        chk("halt_pc6", io.PC_Out, 6);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("resume_rom6", io.IR_Out, 16'h8933);
        wait_state(4'd10, 1'b0, n);
        chk("ldi_r9", io.ALU_A, 16'h0033);

        // Illegal opcode
        clear_rom();
        rom[0] = 16'h8107; rom[1] = 16'hB123; rom[3] = 16'hF010;
        step(1'b1, 1'b0);
        wait_state(4'd3, 1'b0, n);
        chk("illegal_err", {io.Err, io.IR_Out}, {1'b1, 16'hB123});
        wait_state(4'd10, 1'b0, n);
        chk("err_sticky", io.Err, 1);
        chk("illegal_r1", io.ALU_A, 16'h0007);
        step(1'b1, 1'b0);
        chk("err_cleared", io.Err, 0);

        // Random programs; preamble initialises the data words loads may touch
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 8; i++) rom[i] = 16'h2020 + 16'(i);
            for (int i = 8; i < 128; i++) begin
                logic [3:0] op, rd;
                logic [7:0] v;
                op = 4'($urandom_range(0, 15));
                rd = 4'($urandom_range(0, 15));
                v  = 8'($urandom_range(0, 255));
                if (op == 4'h1 || op == 4'h2) v = 8'h20 + 8'($urandom_range(0, 7));
                rom[i] = {op, rd, v};
            end
            step(1'b1, 1'b0);
            for (int c = 0; c < 400; c++)
                step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/processor_core_p.md
# processor_core_p

Parametrised multi-cycle processor core: FSM controller, 16-entry register file, internal data memory and ALU in one block, fetching 16-bit instructions from an external combinational instruction ROM. Generalises the fixed 16-bit datapath with configurable data width, PC width and data-memory depth. Extends the ISA with logic ops, load-immediate and jump-if-zero. Adds a resumable HALT and a sticky illegal-opcode flag. Debug outputs (IR, PC, state, ALU operands/result) remain visible for board-level observation.

## Interface
- DATA_W, 16, datapath/register/memory word width (legal range 8..32)
- PC_W, 7, instruction address width (legal range 1..8)
- DMEM_AW, 8, data-memory address bits; depth 2**DMEM_AW (legal range 1..8)

- Clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state listed below
- Instr  in  16  instruction word at PC_Out, valid combinationally in the same cycle
- Resume  in  1  leave HALT; sampled only in HALT
- PC_Out  out  PC_W  program counter / instruction-ROM address
- IR_Out  out  16  instruction register
- State  out  4  current FSM state encoding
- ALU_A, ALU_B  out  DATA_W  RF[IR[7:4]], RF[IR[3:0]] (combinational reads)
- ALU_Out  out  DATA_W  combinational ALU result
- Halted  out  1  high while State==HALT
- Err  out  1  sticky illegal-opcode flag

## Operation
- Formats: op=IR[15:12], rd=IR[11:8], ra=IR[7:4], rb=IR[3:0], imm/addr=IR[7:0].
- Opcodes: 0 NOOP; 1 LOAD rd<=DMEM[addr]; 2 STORE DMEM[addr]<=RF[rd]; 3 ADD; 4 SUB (ra-rb); 5 AND; 6 OR; 7 XOR (all rd<=ra op rb); 8 LDI rd<=zero-extended imm; 9 JZ: if RF[rd]==0 then PC<=addr[PC_W-1:0]; F HALT; A-E illegal.
- Memory address: addr[DMEM_AW-1:0]; upper bits ignored.
- Arithmetic is modulo 2**DATA_W; no carry/overflow output.
- For ops other than 3-7, ALU_Out = ALU_A.
- States (encoding): INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ALU=7, LDI=8, JZ=9, HALT=10.
- INIT -> FETCH unconditionally.
- FETCH: IR<=Instr, PC<=PC+1 (wraps 2**PC_W-1 -> 0); -> DECODE.
- DECODE dispatches by op: 0 -> NOOP; 1 -> LOAD_A; 2 -> STORE; 3-7 -> ALU; 8 -> LDI; 9 -> JZ; F -> HALT.
- DECODE with an illegal op (A-E): Err<=1 and -> NOOP.
- LOAD_A registers DMEM[addr]; LOAD_B writes it to RF[rd]. The write lands in STORE, ALU, LDI and LOAD_B at the end of that state.
- All execute states return to FETCH.
- HALT: PC already points past the HALT instruction. Resume=1 -> FETCH; otherwise stay in HALT.
- Resume outside HALT is ignored.
- Reset values: PC=0, IR=0, State=INIT, all 16 RF entries=0, Err=0, Halted=0. DMEM is not cleared.
- Reset mid-instruction aborts it: no RF or DMEM write occurs in the cycle Reset is high.

## Timing
- Cycles per instruction, counted from FETCH: NOOP/ALU/STORE/LDI/JZ/illegal = 3; LOAD = 4; HALT = 2 to enter.
- First FETCH is the 2nd rising edge after Reset deasserts (INIT occupies one cycle).
- RF written on the clock edge ending the execute state. The next instruction's DECODE sees the new value; no hazards exist.
- STORE followed by LOAD of the same address returns the stored value.
- JZ taken: the next FETCH uses the target. Not taken: the next FETCH uses PC (already incremented).
- Halted rises in the first HALT cycle. Resume sampled high on edge N gives State=FETCH after edge N.

## Test plan
- Reset/INIT: assert Reset mid-ALU with rd=3 -> State=0, PC=0, IR=0, RF[3] unchanged at 0. After release, FETCH at cycle 2 reads ROM[0].
- Arithmetic, DATA_W=16: LDI R1,0xFF; LDI R2,0x01; ADD R3,R1,R2; SUB R4,R2,R1 -> R3=0x0100, R4=0xFF02. XOR R5,R1,R1 -> 0. Each instruction takes 3 cycles.
- Memory: LDI R1,0x5A; STORE R1,0x20; LOAD R6,0x20 -> ALU_A shows R6=0x5A when ra=6. LOAD State sequence is 1,2,4,5.
- Branch: LDI R0,0; JZ R0,0x10 -> PC_Out=0x10 at next FETCH. LDI R7,1; JZ R7,0x10 -> sequential PC. With PC_W=7, the PC at 0x7F wraps to 0.
- HALT/Resume: HALT at ROM[5] -> Halted=1, PC_Out=6, holds for 10 cycles. Resume pulse -> FETCH of ROM[6]. Resume during ALU has no effect.
- Illegal opcode 0xB123 -> Err=1 in the cycle after DECODE, no register changes, 3-cycle instruction; Err stays high until Reset. Rerun the arithmetic test with DATA_W=8: ADD 0xFF+0x01 -> 0x00.
